// File: rtl/tt_sweep_eval.sv
// tt_sweep_eval: exhaustive sequential evaluator for an N_IN-input boolean function held as a
// programmable truth table. On start the table is latched. The block then steps through every
// input vector 0..2**N_IN-1, one per clock. It captures each output into a result word, counts
// the ones and pulses done.
//
// Parameters:
//   N_IN      number of function inputs (1..8); table depth is 2**N_IN
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     begin a sweep (sampled in IDLE only)
//   abort     stop a running sweep without done
//   cfg_tt    truth table, bit k = f(vector k)
//   vec       vector under evaluation
//   s         f(vec) from the latched table
//   valid     vec/s meaningful this cycle
//   res       captured outputs, bit k = f(k)
//   ones      number of 1 outputs seen so far
//   busy      high while sweeping
//   done      one-cycle pulse at sweep completion
// Optional feature, macro TT_CMP_EN: compares against an expected table exp_tt and reports
//   mism, mism_cnt and first_bad.
module tt_sweep_eval #(
  parameter int unsigned N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   cfg_tt,
`ifdef TT_CMP_EN
  input  logic [2**N_IN-1:0]   exp_tt,
  output logic                 mism,
  output logic [N_IN:0]        mism_cnt,
  output logic [N_IN-1:0]      first_bad,
`endif
  output logic [N_IN-1:0]      vec,
  output logic                 s,
  output logic                 valid,
  output logic [2**N_IN-1:0]   res,
  output logic [N_IN:0]        ones,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned Depth = 2**N_IN;
  localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [Depth-1:0]   tt_q, tt_d;
  logic [Depth-1:0]   res_q, res_d;
  logic [N_IN:0]      ones_q, ones_d;
  logic               run;
  logic               s_bit;

`ifdef TT_CMP_EN
  logic [Depth-1:0]   exp_q, exp_d;
  logic               mism_q, mism_d;
  logic [N_IN:0]      mism_cnt_q, mism_cnt_d;
  logic [N_IN-1:0]    first_bad_q, first_bad_d;
`endif

  assign run   = (state_q == StRun);
  assign s_bit = tt_q[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    res_d   = res_q;
    ones_d  = ones_q;
`ifdef TT_CMP_EN
    exp_d       = exp_q;
    mism_d      = mism_q;
    mism_cnt_d  = mism_cnt_q;
    first_bad_d = first_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        // start has priority over abort here; abort is meaningless outside RUN
        if (start) begin
          state_d = StRun;
          tt_d    = cfg_tt;
          idx_d   = '0;
          res_d   = '0;
          ones_d  = '0;
`ifdef TT_CMP_EN
          exp_d       = exp_tt;
          mism_d      = 1'b0;
          mism_cnt_d  = '0;
          first_bad_d = '0;
`endif
        end
      end
      StRun: begin
        if (abort) begin
          // Partial res/ones are kept; the current vector is not captured
          state_d = StIdle;
        end else begin
          res_d[idx_q] = s_bit;
          ones_d       = ones_q + {{N_IN{1'b0}}, s_bit};
`ifdef TT_CMP_EN
          if (s_bit != exp_q[idx_q]) begin
            mism_d     = 1'b1;
            mism_cnt_d = mism_cnt_q + (N_IN+1)'(1);
            if (!mism_q) first_bad_d = idx_q;
          end
`endif
          // idx parks on the last vector rather than wrapping
          if (idx_q == LastIdx) state_d = StDone;
          else                  idx_d   = idx_q + N_IN'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tt_q    <= '0;
      res_q   <= '0;
      ones_q  <= '0;
`ifdef TT_CMP_EN
      exp_q       <= '0;
      mism_q      <= 1'b0;
      mism_cnt_q  <= '0;
      first_bad_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      res_q   <= res_d;
      ones_q  <= ones_d;
`ifdef TT_CMP_EN
      exp_q       <= exp_d;
      mism_q      <= mism_d;
      mism_cnt_q  <= mism_cnt_d;
      first_bad_q <= first_bad_d;
`endif
    end
  end

  // vec/s are forced low outside RUN so idle outputs never show a stale vector
  assign vec   = run ? idx_q : '0;
  assign s     = run & s_bit;
  assign valid = run;
  assign busy  = run;
  assign done  = (state_q == StDone);
  assign res   = res_q;
  assign ones  = ones_q;

`ifdef TT_CMP_EN
  assign mism      = mism_q;
  assign mism_cnt  = mism_cnt_q;
  assign first_bad = first_bad_q;
`endif

endmodule
